// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bus: the pipeline's register addresses, write/branch flags and the
// forwarding/stall/flush controls returned to it.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [ADDR_W-1:0] WA3E, WA3M, WA3W;
  logic              RegWriteM, RegWriteW, MemtoRegE;
  logic              PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cycles
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall of MEM_LAT
// cycles, branch/PC-write flushes and a saturating stall-cycle counter.
// Optional macro HAZARD_ZERO_REG_EN: register address 0 is hardwired to zero,
// so it never forwards and never causes a load-use stall.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W  = 3,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic {IDLE, LD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       ldhz, pcpend;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, flush_d, flush_e;

  // Address match, honouring the hardwired-zero register when enabled.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
`ifdef HAZARD_ZERO_REG_EN
    return (a == b) && (a != '0);
`else
    return a == b;
`endif
  endfunction

  // Forwarding select: M result beats W result; independent of FSM state.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (hz.RegWriteM && addr_hit(hz.RA1E, hz.WA3M))      fwd_a = 2'b10;
      else if (hz.RegWriteW && addr_hit(hz.RA1E, hz.WA3W)) fwd_a = 2'b01;
      if (hz.RegWriteM && addr_hit(hz.RA2E, hz.WA3M))      fwd_b = 2'b10;
      else if (hz.RegWriteW && addr_hit(hz.RA2E, hz.WA3W)) fwd_b = 2'b01;
    end
  end

  // Hazard conditions seen by the decode stage.
  always_comb begin
    ldhz   = hz.MemtoRegE && (addr_hit(hz.RA1D, hz.WA3E) || addr_hit(hz.RA2D, hz.WA3E));
    pcpend = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  end

  // Stall/flush controls; Mealy in IDLE, forced stall while waiting on a load.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      case (state_q)
        LD_WAIT: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          flush_d = pcpend || hz.PCSrcW || hz.BranchTakenE;
        end
        default: begin
          stall_d = ldhz;
          stall_f = ldhz || pcpend;
          flush_e = ldhz || hz.BranchTakenE;
          flush_d = pcpend || hz.PCSrcW || hz.BranchTakenE;
        end
      endcase
    end
  end

  // Next state: a taken branch aborts any pending load wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.BranchTakenE) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        LD_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_q - 4'd1;
          end
        end
        default: begin
          // First stall cycle is spent in IDLE; remaining MEM_LAT-1 in LD_WAIT.
          if (ldhz && (MEM_LAT > 1)) begin
            state_d = LD_WAIT;
            cnt_d   = 4'(MEM_LAT - 1);
          end
        end
      endcase
    end
  end

  // Saturating count of cycles with decode stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State, wait counter and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.ForwardAE    = fwd_a;
  assign hz.ForwardBE    = fwd_b;
  assign hz.StallF       = stall_f;
  assign hz.StallD       = stall_d;
  assign hz.FlushD       = flush_d;
  assign hz.FlushE       = flush_e;
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (MEM_LAT 1, 3, 4; CNT_W 4)
// share one stimulus stream and are compared every cycle against a model that
// tracks "stall cycles still owed" per instance.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  logic [2:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  logic rwm, rww, m2r, pcd, pce, pcm, pcw, bt;

  logic [2:0][1:0] o_fa, o_fb;
  logic [2:0]      o_sf, o_sd, o_fd, o_fe;
  logic [2:0][3:0] o_cnt;

  int checks = 0;
  int errors = 0;

  int rem  [3];
  int scnt [3];
  logic [1:0] s_fa [3];
  logic       s_sd [3], s_sf [3], s_fd [3], s_fe [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.ADDR_W(3), .CNT_W(4)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].RA1D         = ra1d;
    assign ifs[g].RA2D         = ra2d;
    assign ifs[g].RA1E         = ra1e;
    assign ifs[g].RA2E         = ra2e;
    assign ifs[g].WA3E         = wa3e;
    assign ifs[g].WA3M         = wa3m;
    assign ifs[g].WA3W         = wa3w;
    assign ifs[g].RegWriteM    = rwm;
    assign ifs[g].RegWriteW    = rww;
    assign ifs[g].MemtoRegE    = m2r;
    assign ifs[g].PCSrcD       = pcd;
    assign ifs[g].PCSrcE       = pce;
    assign ifs[g].PCSrcM       = pcm;
    assign ifs[g].PCSrcW       = pcw;
    assign ifs[g].BranchTakenE = bt;
    assign o_fa[g]  = ifs[g].ForwardAE;
    assign o_fb[g]  = ifs[g].ForwardBE;
    assign o_sf[g]  = ifs[g].StallF;
    assign o_sd[g]  = ifs[g].StallD;
    assign o_fd[g]  = ifs[g].FlushD;
    assign o_fe[g]  = ifs[g].FlushE;
    assign o_cnt[g] = ifs[g].stall_cycles;

    pipeline_hazard_ctrl #(
      .ADDR_W (3),
      .MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .CNT_W  (4)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .hz (ifs[g])
    );
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic logic hit(input logic [2:0] a, input logic [2:0] b);
`ifdef HAZARD_ZERO_REG_EN
    return (a == b) && (a != 3'd0);
`else
    return a == b;
`endif
  endfunction

  function automatic logic [1:0] fwd(input logic [2:0] ra);
    if (rst) return 2'b00;
    if (rwm && hit(ra, wa3m)) return 2'b10;
    if (rww && hit(ra, wa3w)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic clear_in();
    ra1d = 0; ra2d = 0; ra1e = 0; ra2e = 0; wa3e = 0; wa3m = 0; wa3w = 0;
    rwm = 0; rww = 0; m2r = 0; pcd = 0; pce = 0; pcm = 0; pcw = 0; bt = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, cross the rising edge.
  task automatic cycle();
    logic ldhz, pcpend, esd, esf, efd, efe;
    @(negedge clk);
    ldhz   = m2r && (hit(ra1d, wa3e) || hit(ra2d, wa3e));
    pcpend = pcd || pce || pcm;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        esd = 0; esf = 0; efd = 0; efe = 0;
      end else if (rem[i] > 0) begin
        esd = 1; esf = 1; efe = 1; efd = pcpend || pcw || bt;
      end else begin
        esd = ldhz; esf = ldhz || pcpend; efe = ldhz || bt; efd = pcpend || pcw || bt;
      end
      s_fa[i] = o_fa[i]; s_sd[i] = o_sd[i]; s_sf[i] = o_sf[i];
      s_fd[i] = o_fd[i]; s_fe[i] = o_fe[i];
      chk("fwd_a", i, o_fa[i], fwd(ra1e));
      chk("fwd_b", i, o_fb[i], fwd(ra2e));
      chk("stall_d", i, o_sd[i], esd);
      chk("stall_f", i, o_sf[i], esf);
      chk("flush_d", i, o_fd[i], efd);
      chk("flush_e", i, o_fe[i], efe);
      chk("stall_cycles", i, o_cnt[i], scnt[i]);
      if (rst) begin
        rem[i] = 0; scnt[i] = 0;
      end else begin
        if (esd && scnt[i] < 15) scnt[i]++;
        if (bt)              rem[i] = 0;
        else if (rem[i] > 0) rem[i]--;
        else if (ldhz)       rem[i] = lat(i) - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    rst = 1;
    for (int i = 0; i < 3; i++) begin rem[i] = 0; scnt[i] = 0; end
    @(posedge clk); #1;
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) chk("reset_cnt", i, o_cnt[i], 0);
    rst = 0;
    cycle();

    // Forward priority: M over W, then W alone.
    ra1e = 3; wa3m = 3; wa3w = 3; rwm = 1; rww = 1;
    cycle();
    chk("fwd_prio_m", 0, s_fa[0], 2'b10);
    rwm = 0;
    cycle();
    chk("fwd_prio_w", 0, s_fa[0], 2'b01);
    clear_in();

    // Load-use stall for one cycle of hazard.
    rst = 1; cycle(); rst = 0;
    m2r = 1; wa3e = 2; ra2d = 2; ra1d = 5;
    cycle();
    m2r = 0;
    cycle();
    cycle();
    chk("lu_third_stall", 1, s_sd[1], 1);
    cycle();
    chk("lu_after_stall", 1, s_sd[1], 0);
    chk("lu_count", 1, o_cnt[1], 3);
    cycle();
    clear_in();

    // Branch abort in the second LD_WAIT cycle.
    m2r = 1; wa3e = 2; ra2d = 2;
    cycle();
    m2r = 0;
    cycle();
    bt = 1;
    cycle();
    chk("abort_flush_d", 1, s_fd[1], 1);
    chk("abort_flush_e", 1, s_fe[1], 1);
    bt = 0;
    cycle();
    chk("abort_no_stall", 2, s_sd[2], 0);
    cycle();
    clear_in();

    // Reset during the second stall cycle of MEM_LAT=4.
    m2r = 1; wa3e = 2; ra2d = 2;
    cycle();
    m2r = 0; rst = 1;
    cycle();
    rst = 0;
    cycle();
    chk("rst_mid_stall_d", 2, s_sd[2], 0);
    chk("rst_mid_flush_e", 2, s_fe[2], 0);
    chk("rst_mid_cnt", 2, o_cnt[2], 0);
    clear_in();

    // Continuous hazard: counter saturates at 15.
    m2r = 1; wa3e = 2; ra2d = 2;
    for (int k = 0; k < 20; k++) cycle();
    for (int i = 0; i < 3; i++) chk("saturate", i, o_cnt[i], 15);
    clear_in();
    cycle();

    // Zero register forwarding.
    wa3m = 0; ra1e = 0; rwm = 1;
    cycle();
`ifdef HAZARD_ZERO_REG_EN
    chk("zero_reg", 0, s_fa[0], 2'b00);
`else
    chk("zero_reg", 0, s_fa[0], 2'b10);
`endif
    clear_in();

    // Random traffic.
    rst = 1; cycle(); rst = 0;
    for (int k = 0; k < 400; k++) begin
      ra1d = 3'($urandom); ra2d = 3'($urandom); ra1e = 3'($urandom); ra2e = 3'($urandom);
      wa3e = 3'($urandom); wa3m = 3'($urandom); wa3w = 3'($urandom);
      rwm = 1'($urandom); rww = 1'($urandom);
      m2r = ($urandom_range(0, 2) == 0);
      pcd = ($urandom_range(0, 5) == 0);
      pce = ($urandom_range(0, 5) == 0);
      pcm = ($urandom_range(0, 5) == 0);
      pcw = ($urandom_range(0, 5) == 0);
      bt  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
